// File: rtl/bin_a_bcd_display_pkg.sv
// Shared definitions for the binary-to-BCD display converter.
// Holds the FSM state encoding and the BCD geometry constants.
package bin_a_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_BCD = 9999;
  localparam int BCD_W = 4;
  localparam int N_DIG = 4;

endpackage

// File: rtl/bin_a_bcd_display_bcd_ajuste_3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift,
// so that the shift carries correctly into the next decimal digit.
module bcd_ajuste_3
  import bin_a_bcd_display_pkg::*;
(
  input  logic [BCD_W-1:0] din_i,
  output logic [BCD_W-1:0] dout_o
);

  assign dout_o = (din_i >= BCD_W'(5)) ? din_i + BCD_W'(3) : din_i;

endmodule

// File: rtl/bin_a_bcd_display.sv
// Iterative binary-to-BCD converter feeding the 4-digit 7-segment display.
// Digits are only written when a conversion completes, so the display never shows partial results.
module bin_a_bcd_display
  import bin_a_bcd_display_pkg::*;
#(
  parameter int BITS = 14
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic [BITS-1:0] i_Valor,
  input  logic            i_Start,
  output logic            o_Busy,
  output logic            o_Done,
  output logic            o_Overflow,
  output logic [3:0]      o_Datos_1,
  output logic [3:0]      o_Datos_2,
  output logic [3:0]      o_Datos_3,
  output logic [3:0]      o_Datos_4
);

  localparam int BCD_TOT = N_DIG * BCD_W;
  localparam int SW      = BCD_TOT + BITS;
  localparam int CW      = $clog2(BITS + 1);

  state_t              state_q;
  logic [SW-1:0]       scratch_q;
  logic [SW-1:0]       scratch_d;
  logic [CW-1:0]       cnt_q;
  logic                ovf_int_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;
  logic [BCD_TOT-1:0]  digits_q;
  logic                ovf_calc;

  // All four nibbles are corrected in parallel; the binary part passes through untouched.
  for (genvar g = 0; g < N_DIG; g++) begin : g_ajuste
    bcd_ajuste_3 u_ajuste (
      .din_i  (scratch_q[BITS + g*BCD_W +: BCD_W]),
      .dout_o (scratch_d[BITS + g*BCD_W +: BCD_W])
    );
  end
  assign scratch_d[BITS-1:0] = scratch_q[BITS-1:0];

  assign ovf_calc = (32'(i_Valor) > MAX_BCD);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Start) begin
            scratch_q <= {{BCD_TOT{1'b0}}, i_Valor};
            cnt_q     <= CW'(BITS);
            ovf_int_q <= ovf_calc;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end else begin
            busy_q <= 1'b0;
          end
        end
        CONV: begin
          scratch_q <= {scratch_d[SW-2:0], 1'b0};
          cnt_q     <= cnt_q - 1'b1;
          busy_q    <= 1'b1;
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: begin
          // Out-of-range values saturate the display to 9999 and flag overflow.
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          ovf_q   <= ovf_int_q;
          digits_q <= ovf_int_q ? {N_DIG{BCD_W'(9)}} : scratch_q[SW-1 -: BCD_TOT];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Overflow = ovf_q;
  assign o_Datos_1  = digits_q[3:0];
  assign o_Datos_2  = digits_q[7:4];
  assign o_Datos_3  = digits_q[11:8];
  assign o_Datos_4  = digits_q[15:12];

endmodule

// File: tb/tb_bin_a_bcd_display.sv
// Self-checking bench for bin_a_bcd_display: table vectors, random values against a
// decimal-arithmetic reference, and hand-written sequences for the timing corner cases.
module tb_bin_a_bcd_display;

  localparam int BITS = 14;

  typedef struct {
    logic [BITS-1:0] valor;
    logic [16:0]     expResult;
  } vec_t;

  logic            i_Clk = 1'b0;
  logic            i_Rst;
  logic [BITS-1:0] i_Valor;
  logic            i_Start;
  logic            o_Busy;
  logic            o_Done;
  logic            o_Overflow;
  logic [3:0]      o_Datos_1;
  logic [3:0]      o_Datos_2;
  logic [3:0]      o_Datos_3;
  logic [3:0]      o_Datos_4;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [16:0] shownResult;
  vec_t        vecs[11];

  bin_a_bcd_display #(.BITS(BITS)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Valor    (i_Valor),
    .i_Start    (i_Start),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Overflow (o_Overflow),
    .o_Datos_1  (o_Datos_1),
    .o_Datos_2  (o_Datos_2),
    .o_Datos_3  (o_Datos_3),
    .o_Datos_4  (o_Datos_4)
  );

  always #5 i_Clk = ~i_Clk;

  // Reference: plain decimal arithmetic, saturating to 9999 with the overflow bit on top.
  function automatic logic [16:0] refResult(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [16:0] dutResult();
    return {o_Overflow, o_Datos_4, o_Datos_3, o_Datos_2, o_Datos_1};
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One full conversion: latency, busy window, digit hold before done, result and nibble range.
  task automatic applyStimulus(input logic [BITS-1:0] v, input logic [16:0] exp, input string tag);
    int   doneAt;
    logic busyOk;
    logic holdOk;
    logic nibOk;
    i_Valor = v;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    i_Valor = BITS'($urandom);
    doneAt  = o_Done ? 0 : -1;
    busyOk  = o_Busy;
    holdOk  = 1'b1;
    for (int c = 1; c <= BITS + 2; c++) begin
      tick();
      if (o_Done) doneAt = (doneAt < 0) ? c : 999;
      if (c <= BITS + 1 && !o_Busy) busyOk = 1'b0;
      if (c == BITS + 2 && o_Busy) busyOk = 1'b0;
      if (c == BITS && dutResult() !== shownResult) holdOk = 1'b0;
    end
    nibOk = (o_Datos_1 <= 4'd9) && (o_Datos_2 <= 4'd9) && (o_Datos_3 <= 4'd9) && (o_Datos_4 <= 4'd9);
    checkOutput({tag, "/latency"}, doneAt, BITS + 1);
    checkOutput({tag, "/busy"}, 32'(busyOk), 32'd1);
    checkOutput({tag, "/hold"}, 32'(holdOk), 32'd1);
    checkOutput({tag, "/result"}, 32'(dutResult()), 32'(exp));
    checkOutput({tag, "/nibbles"}, 32'(nibOk), 32'd1);
    shownResult = exp;
  endtask

  initial begin
    int doneCnt;
    int doneAt;
    logic [BITS-1:0] rv;

    vecs[0]  = '{14'd1579,  {1'b0, 16'h1579}};
    vecs[1]  = '{14'd0,     {1'b0, 16'h0000}};
    vecs[2]  = '{14'd9999,  {1'b0, 16'h9999}};
    vecs[3]  = '{14'd12000, {1'b1, 16'h9999}};
    vecs[4]  = '{14'd42,    {1'b0, 16'h0042}};
    vecs[5]  = '{14'd10000, {1'b1, 16'h9999}};
    vecs[6]  = '{14'd16383, {1'b1, 16'h9999}};
    vecs[7]  = '{14'd9,     {1'b0, 16'h0009}};
    vecs[8]  = '{14'd10,    {1'b0, 16'h0010}};
    vecs[9]  = '{14'd1000,  {1'b0, 16'h1000}};
    vecs[10] = '{14'd8080,  {1'b0, 16'h8080}};

    i_Rst   = 1'b1;
    i_Start = 1'b0;
    i_Valor = '0;
    shownResult = '0;
    #22;
    i_Rst = 1'b0;
    tick();
    checkOutput("reset", {13'd0, o_Busy, o_Done, dutResult()}, 32'd0);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i].valor, vecs[i].expResult, "table");

    for (int i = 0; i < 12; i++) begin
      rv = BITS'($urandom_range(0, 16383));
      applyStimulus(rv, refResult(int'(rv)), "random");
    end

    // A start request in the middle of a conversion must be dropped, not queued.
    i_Valor = 14'd1579;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    repeat (4) tick();
    i_Valor = 14'd8888;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    doneCnt = 0;
    doneAt  = -1;
    for (int c = 6; c <= BITS + 8; c++) begin
      tick();
      if (o_Done) begin
        doneCnt++;
        doneAt = c;
      end
    end
    checkOutput("ignored/doneCount", doneCnt, 1);
    checkOutput("ignored/doneAt", doneAt, BITS + 1);
    checkOutput("ignored/result", 32'(dutResult()), 32'({1'b0, 16'h1579}));
    checkOutput("ignored/idle", 32'(o_Busy), 32'd0);
    shownResult = {1'b0, 16'h1579};

    // Asynchronous reset in the middle of a conversion, then a clean restart.
    applyStimulus(14'd8888, {1'b0, 16'h8888}, "preReset");
    i_Valor = 14'd1234;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    repeat (6) tick();
    @(posedge i_Clk);
    #2 i_Rst = 1'b1;
    #1;
    checkOutput("midReset", {13'd0, o_Busy, o_Done, dutResult()}, 32'd0);
    #3 i_Rst = 1'b0;
    shownResult = '0;
    applyStimulus(14'd321, {1'b0, 16'h0321}, "postReset");

    // Start held high: back-to-back conversions, each using the value present at its accept edge.
    i_Valor = '0;
    i_Start = 1'b1;
    tick();
    for (int n = 0; n <= 20; n++) begin
      i_Valor = BITS'(n + 1);
      doneAt  = -1;
      for (int c = 1; c <= BITS + 1; c++) begin
        tick();
        if (o_Done) doneAt = (doneAt < 0) ? c : 999;
      end
      checkOutput("held/doneAt", doneAt, BITS + 1);
      checkOutput("held/result", 32'(dutResult()), 32'(refResult(n)));
      tick();
    end
    i_Start = 1'b0;
    repeat (BITS + 2) tick();
    checkOutput("held/last", 32'(dutResult()), 32'(refResult(21)));
    checkOutput("held/idle", {30'd0, o_Busy, o_Done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
